// File: rtl/fifo_pkg.sv
// Shared defaults and error-flag type for the threshold FIFO family.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned FIFO_ADDR_WIDTH = 4;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage : fifo_pkg

// File: rtl/sync_fifo_th_if.sv
// Data/handshake bundle of sync_fifo_th; master drives requests, slave is the FIFO.
interface sync_fifo_th_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);

  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  rd_en;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output din, wr_en, rd_en, err_clr,
    input  dout, full, almost_full, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en, err_clr,
    output dout, full, almost_full, empty, almost_empty, count, overflow, underflow
  );

endinterface : sync_fifo_th_if

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH flop storage: one synchronous write port, one combinational read port, no reset.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : fifo_mem

// File: rtl/sync_fifo_th.sv
// Single-clock FIFO with almost-full/empty thresholds, fill count and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered dout.
module sync_fifo_th
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  sync_fifo_th_if.slave  bus
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(AE_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_th: AF_LEVEL=%0d outside 1..%0d", AF_LEVEL, DEPTH);
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_th: AE_LEVEL=%0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
  end

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] rdata;
  fifo_err_t             err_q;
  fifo_err_t             err_set;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags decode the registered count, so they lag an accepted operation by one cycle.
  assign full_w  = (count_q == DEPTH_CNT);
  assign empty_w = (count_q == '0);
  assign wr_acc  = bus.wr_en && !full_w;
  assign rd_acc  = bus.rd_en && !empty_w;

  always_comb begin
    err_set           = '0;
    err_set.overflow  = bus.wr_en && full_w;
    err_set.underflow = bus.rd_en && empty_w;
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A new error event in the clearing cycle keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q.overflow  <= err_set.overflow  | (err_q.overflow  & ~bus.err_clr);
      err_q.underflow <= err_set.underflow | (err_q.underflow & ~bus.err_clr);
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.dout = empty_w ? '0 : rdata;
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= rdata;
    end
  end

  assign bus.dout = dout_q;
`endif

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.count        = count_q;
  assign bus.overflow     = err_q.overflow;
  assign bus.underflow    = err_q.underflow;

endmodule : sync_fifo_th

// File: tb/tb_sync_fifo_th.sv
// Scoreboard bench for sync_fifo_th (DEPTH=16); honours FIFO_FWFT_EN like the RTL.
module tb_sync_fifo_th;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sync_fifo_th_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  sync_fifo_th #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .AF_LEVEL   (14),
    .AE_LEVEL   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0] model_q [$];
  logic [7:0] exp_q   [$];
  logic       rd_tag  = 1'b0;
  logic       pend    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle; the reference queue decides acceptance from its pre-edge occupancy.
  task automatic cyc(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    logic wr_ok;
    logic rd_ok;
    wr_ok = wr && (model_q.size() < 16);
    rd_ok = rd && (model_q.size() > 0);
    bus.wr_en   = wr;
    bus.din     = d;
    bus.rd_en   = rd;
    bus.err_clr = clr;
    rd_tag      = rd_ok;
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    @(posedge clk);
    if (wr_ok) model_q.push_back(d);
    #1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.err_clr = 1'b0;
    rd_tag      = 1'b0;
  endtask

  always @(posedge clk) pend = rd_tag;

  always @(negedge clk) begin
    logic do_chk;
`ifdef FIFO_FWFT_EN
    do_chk = rd_tag;
`else
    do_chk = pend;
`endif
    if (do_chk) begin
      if (exp_q.size() == 0) begin
        chk("sb_underrun", 32'd1, 32'd0);
      end else begin
        chk("sb_dout", 32'(bus.dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hold;
    bus.din = '0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.err_clr = 1'b0;
    #12;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_aempty", 32'(bus.almost_empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_afull", 32'(bus.almost_full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_unf", 32'(bus.underflow), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill 0x01..0x10 with no reads.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_count", 32'(bus.count), 32'(i));
      chk("fill_empty", 32'(bus.empty), 0);
      chk("fill_afull", 32'(bus.almost_full), (i >= 14) ? 1 : 0);
      chk("fill_aempty", 32'(bus.almost_empty), (i <= 2) ? 1 : 0);
      chk("fill_full", 32'(bus.full), (i == 16) ? 1 : 0);
    end
`ifdef FIFO_FWFT_EN
    chk("fwft_head", 32'(bus.dout), 32'h01);
`endif

    // Write while full is dropped and flagged.
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 16);
    // Read+write while full: read accepted, write dropped.
    cyc(1'b1, 8'hBB, 1'b1, 1'b0);
    chk("fullrw_count", 32'(bus.count), 15);
    chk("fullrw_notfull", 32'(bus.full), 0);

    for (int i = 0; i < 15; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_count", 32'(bus.count), 32'(14 - i));
    end
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_unf", 32'(bus.underflow), 0);

`ifdef FIFO_FWFT_EN
    hold = 8'h00;
`else
    hold = 8'h10;
`endif
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_set", 32'(bus.underflow), 1);
    chk("unf_dout", 32'(bus.dout), 32'(hold));
    chk("unf_count", 32'(bus.count), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_unf", 32'(bus.underflow), 0);
    chk("clr_ovf", 32'(bus.overflow), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("clr_setwins", 32'(bus.underflow), 1);

    // Steady state at count=5 with concurrent read/write; pointers wrap.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 8'(8'h25 + i), 1'b1, 1'b0);
      chk("sim_count", 32'(bus.count), 5);
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("sim_empty", 32'(bus.empty), 1);

    // Single word into empty FIFO.
    cyc(1'b1, 8'h5C, 1'b0, 1'b0);
    chk("w5c_empty", 32'(bus.empty), 0);
`ifdef FIFO_FWFT_EN
    chk("w5c_fwft", 32'(bus.dout), 32'h5C);
    hold = 8'h00;
`else
    hold = 8'h5C;
`endif
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("r5c_empty", 32'(bus.empty), 1);
    chk("r5c_dout", 32'(bus.dout), 32'(hold));
    cyc(1'b0, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset with seven words stored.
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_empty", 32'(bus.empty), 1);
    chk("arst_dout", 32'(bus.dout), 0);
    chk("arst_unf", 32'(bus.underflow), 0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_count", 32'(bus.count), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sync_fifo_th
